// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register feeding the EX-stage ALU.
// It captures the decoded operands, the immediate and the ALU control. RAW
// hazards on rs1 and rs2 are resolved at capture by forwarding from EX/MEM and
// MEM/WB. The entry is held under a valid/ready handshake, and a flush input
// kills it.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid / in_ready           decode-side handshake (in_ready combinational)
//   rs1_addr, rs2_addr            source register indices
//   rs1_data, rs2_data, imm       register-file read data and immediate
//   ALUsrc, ALUctrl_in            op2 select (1 = imm) and ALU operation
//   rd_addr, reg_write            destination and write enable
//   exmem_*, memwb_*              forwarding sources (rd, regwrite, value)
//   flush                         kills the held and the incoming instruction
//   out_valid / out_ready         EX-side handshake
//   ALUop1, ALUop2, ALUctrl       registered ALU inputs
//   store_data                    forwarded rs2, independent of ALUsrc
//   rd_out, reg_write_out         destination and write enable passed to EX
module id_ex_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REGADDR-1:0] rs1_addr,
  input  logic [REGADDR-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic               ALUsrc,
  input  logic [2:0]         ALUctrl_in,
  input  logic [REGADDR-1:0] rd_addr,
  input  logic               reg_write,
  input  logic [REGADDR-1:0] exmem_rd,
  input  logic               exmem_regwrite,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [REGADDR-1:0] memwb_rd,
  input  logic               memwb_regwrite,
  input  logic [XLEN-1:0]    memwb_result,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    ALUop1,
  output logic [XLEN-1:0]    ALUop2,
  output logic [2:0]         ALUctrl,
  output logic [XLEN-1:0]    store_data,
  output logic [REGADDR-1:0] rd_out,
  output logic               reg_write_out
);

  logic            capture;
  logic            consume;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Operand forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGADDR-1:0] rs,
    input logic [XLEN-1:0]    rf_data,
    input logic [REGADDR-1:0] em_rd,
    input logic               em_we,
    input logic [XLEN-1:0]    em_val,
    input logic [REGADDR-1:0] mw_rd,
    input logic               mw_we,
    input logic [XLEN-1:0]    mw_val
  );
    logic [XLEN-1:0] res;
    res = rf_data;
    if (rs != '0) begin
      if (em_we && (em_rd == rs)) begin
        res = em_val;
      end else if (mw_we && (mw_rd == rs)) begin
        res = mw_val;
      end
    end
    return res;
  endfunction

  // Handshake and forwarding decode.
  always_comb begin
    in_ready = 1'b1;
    capture  = 1'b0;
    consume  = 1'b0;
    fwd_rs1  = '0;
    fwd_rs2  = '0;
    in_ready = !out_valid || out_ready;
    capture  = in_valid && in_ready && !flush;
    consume  = out_valid && out_ready;
    fwd_rs1  = fwd_sel(rs1_addr, rs1_data, exmem_rd, exmem_regwrite, exmem_result,
                       memwb_rd, memwb_regwrite, memwb_result);
    fwd_rs2  = fwd_sel(rs2_addr, rs2_data, exmem_rd, exmem_regwrite, exmem_result,
                       memwb_rd, memwb_regwrite, memwb_result);
  end

  // Pipeline register: reset > flush > capture > consume > hold.
  // Data fields are left untouched on flush/consume; only valid and the
  // write enable are cleared so a dead entry can never write the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      ALUop1        <= '0;
      ALUop2        <= '0;
      ALUctrl       <= '0;
      store_data    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      ALUop1        <= fwd_rs1;
      ALUop2        <= ALUsrc ? imm : fwd_rs2;
      ALUctrl       <= ALUctrl_in;
      store_data    <= fwd_rs2;
      rd_out        <= rd_addr;
      reg_write_out <= reg_write;
    end else if (consume) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Expected entries are pushed to a scoreboard
// queue when the bench drives a capture and are checked and popped when the
// stage presents and hands them off.
module tb_id_ex_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REGADDR = 5;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ctrl;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [31:0] rw;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [REGADDR-1:0] rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd;
  logic [XLEN-1:0]    rs1_data, rs2_data, imm, exmem_result, memwb_result;
  logic               ALUsrc, reg_write, exmem_regwrite, memwb_regwrite, flush;
  logic [2:0]         ALUctrl_in;
  logic               out_valid, out_ready;
  logic [XLEN-1:0]    ALUop1, ALUop2, store_data;
  logic [2:0]         ALUctrl;
  logic [REGADDR-1:0] rd_out;
  logic               reg_write_out;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];
  bit   m_valid = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REGADDR(REGADDR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .ALUsrc(ALUsrc), .ALUctrl_in(ALUctrl_in), .rd_addr(rd_addr),
    .reg_write(reg_write), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .memwb_result(memwb_result), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference forwarding model.
  function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (exmem_regwrite && exmem_rd == a) return exmem_result;
    if (memwb_regwrite && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_op1"}, ALUop1, 32'd0);
    chk({tag, "_op2"}, ALUop2, 32'd0);
    chk({tag, "_ctrl"}, 32'(ALUctrl), 32'd0);
    chk({tag, "_sd"}, store_data, 32'd0);
    chk({tag, "_rd"}, 32'(rd_out), 32'd0);
    chk({tag, "_rw"}, 32'(reg_write_out), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic set_in(input bit v, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] im,
                        input bit src, input logic [2:0] ctl, input logic [4:0] rd, input bit rw);
    in_valid = v; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    imm = im; ALUsrc = src; ALUctrl_in = ctl; rd_addr = rd; reg_write = rw;
  endtask

  task automatic set_fwd(input bit ew, input logic [4:0] erd, input logic [31:0] ev,
                         input bit mw, input logic [4:0] mrd, input logic [31:0] mv);
    exmem_regwrite = ew; exmem_rd = erd; exmem_result = ev;
    memwb_regwrite = mw; memwb_rd = mrd; memwb_result = mv;
  endtask

  // One clock: check at negedge, advance the model, then step past posedge.
  task automatic cycle(input string tag);
    bit   exp_ready;
    exp_t e;
    @(negedge clk);
    exp_ready = !m_valid || out_ready;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      e = sb[0];
      chk({tag, "_op1"}, ALUop1, e.op1);
      chk({tag, "_op2"}, ALUop2, e.op2);
      chk({tag, "_ctrl"}, 32'(ALUctrl), e.ctrl);
      chk({tag, "_sd"}, store_data, e.sd);
      chk({tag, "_rd"}, 32'(rd_out), e.rd);
      chk({tag, "_rw"}, 32'(reg_write_out), e.rw);
    end else begin
      chk({tag, "_rw_idle"}, 32'(reg_write_out), 32'd0);
    end
    if (!rst_n || flush) begin
      sb.delete();
      m_valid = 1'b0;
    end else if (in_valid && exp_ready) begin
      if (m_valid) void'(sb.pop_front());
      e.op1  = model_fwd(rs1_addr, rs1_data);
      e.sd   = model_fwd(rs2_addr, rs2_data);
      e.op2  = ALUsrc ? imm : e.sd;
      e.ctrl = 32'(ALUctrl_in);
      e.rd   = 32'(rd_addr);
      e.rw   = 32'(reg_write);
      sb.push_back(e);
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      void'(sb.pop_front());
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Basic capture, no forwarding.
    set_in(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 3'b000, 5'd4, 1);
    cycle("basic_cap");
    // EX/MEM beats MEM/WB on rs1.
    set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    set_in(1, 5'd3, 32'h55, 5'd2, 32'd7, 32'd0, 0, 3'b001, 5'd5, 1);
    cycle("fwd_exmem");
    // x0 never forwarded even with matching writers.
    set_fwd(1, 5'd0, 32'h10, 1, 5'd0, 32'h20);
    set_in(1, 5'd0, 32'h66, 5'd0, 32'h88, 32'd0, 0, 3'b010, 5'd6, 0);
    cycle("fwd_x0");
    // Immediate op2, rs2 forwarded from MEM/WB into store_data.
    set_fwd(1, 5'd7, 32'hAA, 1, 5'd6, 32'd9);
    set_in(1, 5'd1, 32'h11, 5'd6, 32'h77, 32'hFFFF_FFFC, 1, 3'b011, 5'd8, 1);
    cycle("imm_sel");
    set_fwd(0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    cycle("imm_out");

    // Stall with an entry held while decode keeps offering new work.
    set_in(1, 5'd9, 32'h1234, 5'd10, 32'h5678, 32'd0, 0, 3'b001, 5'd11, 1);
    cycle("stall_cap");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(i + 12), $urandom, 5'(i + 2), $urandom, $urandom, 1'($urandom),
             3'($urandom), 5'(i + 1), 1'($urandom));
      cycle("stall_hold");
    end
    out_ready = 1'b1;
    set_in(1, 5'd13, 32'hCAFE, 5'd14, 32'hBEEF, 32'd0, 0, 3'b010, 5'd15, 1);
    cycle("no_bubble");
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    cycle("no_bubble_out");

    // Flush while holding, incoming instruction must be dropped.
    set_in(1, 5'd16, 32'h100, 5'd17, 32'h200, 32'd0, 0, 3'b000, 5'd18, 1);
    cycle("flush_cap");
    out_ready = 1'b0;
    set_in(1, 5'd19, 32'h300, 5'd20, 32'h400, 32'd0, 0, 3'b001, 5'd21, 1);
    flush = 1'b1;
    cycle("flush_hold");
    flush = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    cycle("flush_after");
    cycle("flush_idle");

    // Reset mid-stall.
    set_in(1, 5'd22, 32'h500, 5'd23, 32'h600, 32'd0, 0, 3'b011, 5'd24, 1);
    cycle("rst_cap");
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    cycle("rst_stall");
    rst_n = 1'b0;
    cycle("rst_assert");
    check_zero("rst_mid");
    rst_n = 1'b1;

    // Mixed traffic with forwarding, stalls and flushes.
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 9) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      set_in(1'($urandom), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)),
             $urandom, $urandom, 1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      cycle("mixed");
    end
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    cycle("drain");
    cycle("drain_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Single-entry ID/EX pipeline register that feeds the combinational ALU in the EX stage.
- Captures decoded register-file operands, immediate and ALU control from decode.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Presents ALUop1, ALUop2 and ALUctrl, held stable under a valid/ready handshake, with a flush input for taken branches.

Parameters:
- XLEN, 32, datapath width of operands and results
- REGADDR, 5, register address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept this cycle
- rs1_addr  input  REGADDR  source 1 register index
- rs2_addr  input  REGADDR  source 2 register index
- rs1_data  input  XLEN  register-file read data 1
- rs2_data  input  XLEN  register-file read data 2
- imm  input  XLEN  sign-extended immediate
- ALUsrc  input  1  1 selects imm as op2, 0 selects forwarded rs2
- ALUctrl_in  input  3  ALU operation (000 add, 001 sub, 010 and, 011 or)
- rd_addr  input  REGADDR  destination register
- reg_write  input  1  instruction writes rd
- exmem_rd  input  REGADDR  EX/MEM destination
- exmem_regwrite  input  1  EX/MEM will write
- exmem_result  input  XLEN  EX/MEM ALU result
- memwb_rd  input  REGADDR  MEM/WB destination
- memwb_regwrite  input  1  MEM/WB will write
- memwb_result  input  XLEN  MEM/WB writeback value
- flush  input  1  kill held and incoming instruction
- out_valid  output  1  EX holds a valid instruction
- out_ready  input  1  downstream consumes this cycle
- ALUop1  output  XLEN  ALU operand 1
- ALUop2  output  XLEN  ALU operand 2
- ALUctrl  output  3  ALU operation
- store_data  output  XLEN  forwarded rs2 value, regardless of ALUsrc
- rd_out  output  REGADDR  destination passed to EX
- reg_write_out  output  1  write enable; forced 0 when out_valid=0

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs and registers go to 0: out_valid=0, ALUop1=ALUop2=store_data=0, ALUctrl=000, rd_out=0, reg_write_out=0.
  - Reset takes priority over flush and capture. in_ready is combinational and reads 1 after reset.
- Handshake:
  - in_ready = !out_valid | out_ready. It is combinational and does not depend on in_valid.
  - Capture = in_valid & in_ready & !flush. Latency is 1 cycle from capture to outputs.
  - Consume = out_valid & out_ready.
- Next state at each posedge:
  - flush: out_valid←0 and reg_write_out←0. Data registers may retain their values.
  - else capture: load all fields, out_valid←1.
  - else consume: out_valid←0, reg_write_out←0.
  - else hold: every output bit is unchanged.
- Simultaneous consume and capture: the new instruction replaces the old one with no bubble, giving full throughput of 1 per cycle.
- Hold while stalled: ALUop1, ALUop2, ALUctrl, store_data and rd_out stay bit-stable for as long as out_valid=1 and out_ready=0.
- Forwarding is evaluated once, at capture, separately for rs1 and for rs2:
  - If exmem_regwrite & exmem_rd==rsX & rsX!=0, use exmem_result.
  - Else if memwb_regwrite & memwb_rd==rsX & rsX!=0, use memwb_result.
  - Else use rsX_data.
  - EX/MEM has priority over MEM/WB when both match.
  - x0 is never forwarded.
  - Forwarded operands are not re-resolved while held. The pipeline control stalls EX/MEM and MEM/WB with this stage, so they stay consistent.
- Operand selection:
  - ALUop1 = fwd_rs1.
  - ALUop2 = ALUsrc ? imm : fwd_rs2.
  - store_data = fwd_rs2.
- Width: all data fields are XLEN bits and are passed through unmodified. No arithmetic is done in this stage.
- Flush during hold discards the held instruction. The in_valid presented in the same cycle is dropped, not captured.
- Reset mid-stall discards the held entry with no residual valid.

Test Plan:
- Reset, then in_valid=1 with rs1_data=5, rs2_data=7, ALUsrc=0, ALUctrl_in=000, no forwarding → next cycle out_valid=1, ALUop1=5, ALUop2=7, ALUctrl=000.
- exmem_regwrite=1, exmem_rd=3=rs1_addr, exmem_result=0x10; memwb_regwrite=1, memwb_rd=3, memwb_result=0x20 → ALUop1=0x10. Repeat with rs1_addr=0 → ALUop1=rs1_data.
- ALUsrc=1, imm=0xFFFFFFFC, rs2 forwarded from MEM/WB as 9 → ALUop2=0xFFFFFFFC, store_data=9.
- Hold out_ready=0 for 4 cycles with in_valid=1 and changing inputs → in_ready=0 and outputs stable. Raise out_ready → next instruction captured in the same cycle as consume, with no bubble.
- flush=1 while holding and in_valid=1 → next cycle out_valid=0, reg_write_out=0, and the incoming instruction is never presented.
- rst_n=0 while out_valid=1 and stalled → next cycle all outputs 0, in_ready=1.
